// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit driving the datapath strobes one step per clock.
module control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic [31:0]         IR,
    input  logic                Stop,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                Read,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zhighout,
    output logic                Zlowout,
    output logic                HIin,
    output logic                LOin,
    output logic                Cout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [OPW-1:0]      opcode,
    output logic                Run,
    output logic                illegal
);
    typedef enum logic [3:0] {S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;

    state_t r_state;

    logic [4:0]          w_op;
    logic [3:0]          w_ra, w_rb, w_rc;
    logic [NUM_REGS-1:0] w_sel_ra, w_sel_rb, w_sel_rc;
    logic                w_rr, w_imm, w_nn, w_md, w_nop, w_hlt, w_ill;
    logic                w_t0, w_t1, w_t2, w_t3, w_t4, w_t5, w_t6, w_last;
    logic                w_unused;

    assign w_op     = IR[31:27];
    assign w_ra     = IR[26:23];
    assign w_rb     = IR[22:19];
    assign w_rc     = IR[18:15];
    assign w_unused = &{1'b0, IR[14:0]};

    assign w_sel_ra = NUM_REGS'(1) << w_ra;
    assign w_sel_rb = NUM_REGS'(1) << w_rb;
    assign w_sel_rc = NUM_REGS'(1) << w_rc;

    assign w_rr  = w_op >= 5'd3 && w_op <= 5'd11;
    assign w_imm = w_op >= 5'd12 && w_op <= 5'd14;
    assign w_md  = w_op == 5'd15 || w_op == 5'd16;
    assign w_nn  = w_op == 5'd17 || w_op == 5'd18;
    assign w_nop = w_op == 5'd25;
    assign w_hlt = w_op == 5'd26;
    assign w_ill = !(w_rr || w_imm || w_md || w_nn || w_nop || w_hlt);

    assign w_t0 = r_state == S_T0;
    assign w_t1 = r_state == S_T1;
    assign w_t2 = r_state == S_T2;
    assign w_t3 = r_state == S_T3;
    assign w_t4 = r_state == S_T4;
    assign w_t5 = r_state == S_T5;
    assign w_t6 = r_state == S_T6;

    // Final execute step of each instruction class; this is where Stop is honoured.
    assign w_last = (w_t3 && (w_nop || w_ill)) || (w_t4 && w_nn) ||
                    (w_t5 && (w_rr || w_imm)) || w_t6;

    always_ff @(posedge Clock) begin
        if (clear)
            r_state <= S_RST;
        else if (w_last)
            r_state <= Stop ? S_HALT : S_T0;
        else if (w_t3 && w_hlt)
            r_state <= S_HALT;
        else if (r_state != S_HALT)
            r_state <= state_t'(r_state + 4'd1);
    end

    assign PCout    = w_t0;
    assign MARin    = w_t0;
    assign IncPC    = w_t0;
    assign PCin     = w_t1;
    assign Read     = w_t1;
    assign MDRin    = w_t1;
    assign MDRout   = w_t2;
    assign IRin     = w_t2;
    assign Yin      = w_t3 && (w_rr || w_imm || w_md);
    assign Zin      = w_t0 || (w_t3 && w_nn) || (w_t4 && (w_rr || w_imm || w_md));
    assign Zlowout  = w_t1 || (w_t4 && w_nn) || (w_t5 && (w_rr || w_imm || w_md));
    assign Zhighout = w_t6 && w_md;
    assign HIin     = w_t6 && w_md;
    assign LOin     = w_t5 && w_md;
    assign Cout     = w_t4 && w_imm;
    assign illegal  = w_t3 && w_ill;
    assign Run      = r_state != S_RST && r_state != S_HALT;

    assign Rin  = ((w_t4 && w_nn) || (w_t5 && (w_rr || w_imm))) ? w_sel_ra : '0;
    assign Rout = (w_t3 && (w_rr || w_imm || w_nn)) ? w_sel_rb :
                  (w_t3 && w_md)                    ? w_sel_ra :
                  (w_t4 && w_rr)                    ? w_sel_rc :
                  (w_t4 && w_md)                    ? w_sel_rb : '0;

    // Immediate forms reuse the add/and/or ALU operations.
    assign opcode = w_t0                                       ? OPW'(5'd3) :
                    ((w_t3 && w_nn) || (w_t4 && (w_rr || w_md))) ? OPW'(w_op) :
                    (w_t4 && w_imm)                            ? OPW'(w_op == 5'd12 ? 5'd3 :
                                                                      w_op == 5'd13 ? 5'd5 : 5'd6) :
                                                                 '0;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: step-list model of each instruction checked every cycle, plus literal spot checks.
module tb_control_sequencer;
    typedef struct packed {
        logic pcout, pcin, incpc, marin, mdrin, mdrout, read, irin;
        logic yin, zin, zhi, zlo, hiin, loin, cout, ill, run;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  opc;
    } vec_t;

    logic        Clock = 1'b0;
    logic        clear, Stop;
    logic [31:0] IR;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin, Cout, Run, illegal;
    logic [15:0] Rin, Rout;
    logic [4:0]  opcode;

    vec_t        dut_v, e;
    vec_t        expq[$];
    vec_t        hist[$];
    vec_t        steps[$];
    logic [31:0] cur_ir;
    int          n_chk = 0;
    int          n_fail = 0;
    int          b, cnt;
    logic [15:0] acc;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin), .Cout(Cout),
        .Rin(Rin), .Rout(Rout), .opcode(opcode), .Run(Run), .illegal(illegal)
    );

    always #5 Clock = ~Clock;

    assign dut_v = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
                    Yin, Zin, Zhighout, Zlowout, HIin, LOin, Cout, illegal, Run,
                    Rin, Rout, opcode};

    always @(negedge Clock) begin
        hist.push_back(dut_v);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            n_chk++;
            if (dut_v !== e) begin
                n_fail++;
                $display("FAIL cycle_%0d: dut=%h model=%h", hist.size() - 1, dut_v, e);
            end
        end
    end

    function automatic logic [15:0] sel(input logic [3:0] x);
        return 16'h1 << x;
    endfunction

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected per-cycle outputs of one whole instruction, fetch included.
    task automatic model(input logic [31:0] ir);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        vec_t v;
        op = ir[31:27];
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];
        steps.delete();
        v = '0; v.run = 1; v.pcout = 1; v.marin = 1; v.incpc = 1; v.zin = 1; v.opc = 5'd3; steps.push_back(v);
        v = '0; v.run = 1; v.zlo = 1; v.pcin = 1; v.read = 1; v.mdrin = 1; steps.push_back(v);
        v = '0; v.run = 1; v.mdrout = 1; v.irin = 1; steps.push_back(v);
        if (op >= 3 && op <= 14) begin
            v = '0; v.run = 1; v.rout = sel(rb); v.yin = 1; steps.push_back(v);
            v = '0; v.run = 1; v.zin = 1;
            if (op <= 11) begin
                v.rout = sel(rc);
                v.opc = op;
            end else begin
                v.cout = 1;
                v.opc = (op == 12) ? 5'd3 : (op == 13) ? 5'd5 : 5'd6;
            end
            steps.push_back(v);
            v = '0; v.run = 1; v.zlo = 1; v.rin = sel(ra); steps.push_back(v);
        end else if (op == 15 || op == 16) begin
            v = '0; v.run = 1; v.rout = sel(ra); v.yin = 1; steps.push_back(v);
            v = '0; v.run = 1; v.rout = sel(rb); v.zin = 1; v.opc = op; steps.push_back(v);
            v = '0; v.run = 1; v.zlo = 1; v.loin = 1; steps.push_back(v);
            v = '0; v.run = 1; v.zhi = 1; v.hiin = 1; steps.push_back(v);
        end else if (op == 17 || op == 18) begin
            v = '0; v.run = 1; v.rout = sel(rb); v.zin = 1; v.opc = op; steps.push_back(v);
            v = '0; v.run = 1; v.zlo = 1; v.rin = sel(ra); steps.push_back(v);
        end else begin
            v = '0; v.run = 1; v.ill = !(op == 25 || op == 26); steps.push_back(v);
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic stp, input logic clr, input vec_t ev);
        @(posedge Clock);
        #1;
        IR = ir;
        Stop = stp;
        clear = clr;
        expq.push_back(ev);
    endtask

    // IR only changes after the IRin step; sf/se drive Stop during fetch/execute.
    task automatic run_instr(input logic [31:0] ir, input logic sf, input logic se, input int clr_at);
        model(ir);
        for (int i = 0; i < steps.size() && i <= clr_at; i++)
            drive(i < 3 ? cur_ir : ir, i < 3 ? sf : se, i == clr_at, steps[i]);
        cur_ir = ir;
    endtask

    task automatic settle;
        @(negedge Clock);
        #1;
        b = hist.size();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1; Stop = 0; IR = '0; cur_ir = '0;
        drive(32'h0, 0, 1, '0);
        drive(32'h0, 0, 0, '0);
        settle;
        lit("rst_vec", 64'(hist[1]), 64'h0);
        lit("rst_run", 64'(hist[1].run), 64'h0);

        run_instr(32'h28918000, 0, 0, 99);
        @(negedge Clock); #1;
        lit("t0_fetch", 64'({hist[b].pcout, hist[b].marin, hist[b].incpc, hist[b].zin, hist[b].opc}), 64'h1E3);
        lit("t1_fetch", 64'({hist[b+1].zlo, hist[b+1].pcin, hist[b+1].read, hist[b+1].mdrin}), 64'hF);
        lit("t2_fetch", 64'({hist[b+2].mdrout, hist[b+2].irin}), 64'h3);
        lit("and_t3_rout", 64'(hist[b+3].rout), 64'h4);
        lit("and_t4_rout", 64'(hist[b+4].rout), 64'h8);
        lit("and_t4_opc", 64'(hist[b+4].opc), 64'h5);
        lit("and_t5_rin", 64'(hist[b+5].rin), 64'h2);
        b = hist.size();

        run_instr(32'h88880000, 0, 0, 99);
        @(negedge Clock); #1;
        lit("neg_t3_rout", 64'(hist[b+3].rout), 64'h2);
        lit("neg_t3_opc", 64'(hist[b+3].opc), 64'h11);
        lit("neg_t4_rin", 64'({hist[b+4].rin, hist[b+4].zlo}), 64'h5);
        cnt = b;
        b = hist.size();

        run_instr(32'h78900000, 0, 0, 99);
        @(negedge Clock); #1;
        lit("neg_len5", 64'(hist[cnt+5].pcout), 64'h1);
        lit("mul_t5", 64'({hist[b+5].loin, hist[b+5].zlo}), 64'h3);
        lit("mul_t6", 64'({hist[b+6].hiin, hist[b+6].zhi}), 64'h3);
        acc = '0;
        for (int i = 0; i < 7; i++) acc |= hist[b+i].rin;
        lit("mul_no_rin", 64'(acc), 64'h0);
        b = hist.size();

        run_instr(32'h60800005, 0, 0, 99);
        @(negedge Clock); #1;
        lit("addi_t4", 64'({hist[b+4].cout, hist[b+4].rout, hist[b+4].opc}), 64'h200003);
        b = hist.size();

        run_instr(32'hF8000000, 0, 0, 99);
        @(negedge Clock); #1;
        cnt = 0;
        for (int i = 0; i < 4; i++) cnt += int'(hist[b+i].ill);
        lit("ill_pulses", 64'(cnt), 64'h1);
        lit("ill_t3", 64'(hist[b+3].ill), 64'h1);
        b = hist.size();

        run_instr(32'h3226C000, 1, 0, 99);
        run_instr(32'h20918000, 0, 0, 99);
        run_instr(32'h42A10000, 0, 0, 99);
        run_instr(32'h5F780000, 0, 0, 99);
        run_instr(32'h6B000007, 0, 0, 99);
        run_instr(32'h7200000F, 0, 0, 99);
        run_instr(32'h81B80000, 0, 0, 99);
        run_instr(32'h90080000, 0, 0, 99);
        run_instr(32'hC8000000, 0, 0, 99);
        run_instr(32'h00000000, 0, 0, 99);
        run_instr(32'h18000000, 0, 0, 99);

        settle;
        run_instr(32'h18918000, 0, 1, 99);
        for (int i = 0; i < 3; i++) drive(cur_ir, 0, 0, '0);
        drive(cur_ir, 0, 1, '0);
        drive(cur_ir, 0, 0, '0);
        @(negedge Clock); #1;
        lit("stop_halt_run", 64'(hist[b+6].run), 64'h0);
        lit("stop_rst", 64'(hist[b+10]), 64'h0);
        b = hist.size();

        run_instr(32'hD0000000, 0, 0, 99);
        for (int i = 0; i < 10; i++) drive(32'h18918000, i[0], 0, '0);
        @(negedge Clock); #1;
        cnt = 0;
        for (int i = 4; i < 14; i++) cnt += int'(hist[b+i] == '0);
        lit("halt_idle10", 64'(cnt), 64'd10);
        drive(cur_ir, 0, 1, '0);
        drive(cur_ir, 0, 0, '0);
        settle;

        run_instr(32'h18918000, 0, 0, 4);
        drive(cur_ir, 0, 0, '0);
        run_instr(32'hC8000000, 0, 0, 99);
        @(negedge Clock); #1;
        acc = '0;
        for (int i = 0; i < 6; i++) acc |= hist[b+i].rin;
        lit("clr_no_rin", 64'(acc), 64'h0);
        lit("clr_rst", 64'(hist[b+5]), 64'h0);
        lit("clr_refetch", 64'(hist[b+6].pcout), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
